bcd_to_binary: RTL
==================

# bcd_to_binary

Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from every digit that is 8 or more. It sits between the display/keypad BCD domain and the binary datapath. It converts a packed BCD word entered by the user or host back into a binary value. A single-cycle start pulse launches a conversion. A one-cycle o_DV pulse returns the result together with an error flag.

## Interface
- DECIMAL_DIGITS, 4, number of packed BCD digits on i_BCD (1..16)
- OUTPUT_WIDTH, 14, binary result width (1..256); must be >= ceil(log2(10^DECIMAL_DIGITS)) for error-free full-range conversion
- i_Clock  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- i_BCD  in  DECIMAL_DIGITS*4  packed BCD, digit 0 in bits [3:0]; sampled only on an accepted start
- i_Start  in  1  start request; accepted only in IDLE
- o_Binary  out  OUTPUT_WIDTH  last result; holds until the next completion
- o_DV  out  1  one-cycle pulse: o_Binary and o_Error are valid
- o_Error  out  1  last result invalid (bad digit or overflow); holds until the next completion
- o_Busy  out  1  high whenever state != IDLE

## Operation
- Internal registers:
  - work_bcd (DECIMAL_DIGITS*4)
  - work_bin (OUTPUT_WIDTH)
  - loop counter (8 bit)
  - digit index ($clog2 width, minimum 1)
  - state (3 bit)
- IDLE:
  - o_DV = 0.
  - On i_Start = 1: load work_bcd <= i_BCD and work_bin <= 0.
  - If any digit of i_BCD is > 9, set the invalid flag and go to DONE. Otherwise go to SHIFT.
  - i_Start = 0: stay in IDLE.
- SHIFT: {work_bcd, work_bin} <= {work_bcd, work_bin} >> 1, so the work_bcd LSB enters the work_bin MSB. Next state is CHECK_SHIFT_INDEX.
- CHECK_SHIFT_INDEX:
  - If loop == OUTPUT_WIDTH-1: loop <= 0, go to DONE.
  - Otherwise: loop <= loop+1, go to SUB.
- SUB: if digit[idx] >= 8, digit[idx] <= digit[idx] - 3, 4-bit result. Next state is CHECK_DIGIT_INDEX.
- CHECK_DIGIT_INDEX:
  - If idx == DECIMAL_DIGITS-1: idx <= 0, go to SHIFT.
  - Otherwise: idx <= idx+1, go to SUB.
- DONE:
  - o_DV <= 1.
  - o_Error <= invalid flag OR (work_bcd != 0), where a nonzero residue means overflow.
  - o_Binary <= invalid ? 0 : work_bin. On overflow o_Binary carries the low OUTPUT_WIDTH bits.
  - Clear the invalid flag and return to IDLE.
- Any undefined state encoding goes to IDLE.
- i_Start is ignored while o_Busy = 1. No queueing.

## Timing
- Reset (reset_n = 0 at an edge) clears:
  - outputs: o_Binary = 0, o_DV = 0, o_Error = 0, o_Busy = 0
  - state = IDLE
  - loop and idx = 0
  - work registers and the invalid flag = 0
- Reset mid-conversion aborts the conversion. No o_DV is produced.
- Valid-input latency, with W = OUTPUT_WIDTH and D = DECIMAL_DIGITS: o_DV is high in the cycle after edge L = (W-1)*(2D+2)+3, counting the start-accepting edge as edge 0.
  - Defaults: L = 133.
  - D=2, W=7: L = 39.
- Invalid-digit latency: L = 2.
- o_DV is high for exactly one cycle. o_Binary and o_Error change only at that same edge.
- o_Busy rises at edge 0 and falls at the edge that asserts o_DV.
- A new i_Start in the o_DV cycle is accepted, since the state is IDLE. Back-to-back throughput is therefore L+1 cycles.
- i_Start high in the same cycle as reset_n = 0: reset wins and the start is dropped.

## Test plan
- Reset, defaults: hold reset_n = 0 for 3 cycles → o_Binary = 0, o_DV = 0, o_Error = 0, o_Busy = 0.
- i_BCD = 0x1234, 1-cycle start → o_DV pulse at L = 133, o_Binary = 0x04D2, o_Error = 0; o_Busy high for exactly the conversion window.
- Extremes, applied back-to-back with each start asserted in the prior o_DV cycle:
  - 0x9999 → 0x270F, no error
  - 0x0000 → 0x0000, no error
  - 0x0001 → 0x0001, no error
- Invalid digit 0x12A4 → o_DV at L = 2, o_Binary = 0, o_Error = 1. A following valid 0x0042 gives 0x002A with o_Error = 0.
- Start re-pulsed at cycles 10 and 50 during the 0x5678 conversion → ignored; exactly one o_DV, o_Binary = 0x162E.
- Reset mid-conversion at cycle 60 → no o_DV, all outputs 0. The next start with 0x0007 gives 0x0007.
- Overflow, with OUTPUT_WIDTH = 13 and D = 4: 0x9999 → o_Error = 1, o_Binary = 0x070F.
- Random regression: 1000 random valid BCD words compared against a reference model.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One conversion per i_Start pulse in IDLE; the result is returned with a one-cycle o_DV.
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 14
) (
  input  logic                        i_Clock,
  input  logic                        reset_n,
  input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
  input  logic                        i_Start,
  output logic [OUTPUT_WIDTH-1:0]     o_Binary,
  output logic                        o_DV,
  output logic                        o_Error,
  output logic                        o_Busy
);

  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam logic [7:0]       LAST_LOOP = 8'(OUTPUT_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DECIMAL_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE              = 3'd0,
    S_SHIFT             = 3'd1,
    S_CHECK_SHIFT_INDEX = 3'd2,
    S_SUB               = 3'd3,
    S_CHECK_DIGIT_INDEX = 3'd4,
    S_DONE              = 3'd5
  } t_state;

  t_state                  r_State;
  logic [BCD_W-1:0]        r_Work_Bcd;
  logic [OUTPUT_WIDTH-1:0] r_Work_Bin;
  logic [7:0]              r_Loop;
  logic [IDX_W-1:0]        r_Idx;
  logic                    r_Invalid;

  logic                            w_Bad_Digit;
  logic [3:0]                      w_Digit;
  logic [BCD_W+OUTPUT_WIDTH-1:0]   w_Shift;

  always_comb begin
    w_Bad_Digit = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (i_BCD[i*4 +: 4] > 4'd9) w_Bad_Digit = 1'b1;
    end
  end

  assign w_Digit = r_Work_Bcd[{r_Idx, 2'b00} +: 4];
  assign w_Shift = {r_Work_Bcd, r_Work_Bin} >> 1;

  always_ff @(posedge i_Clock) begin
    if (!reset_n) begin
      r_State    <= S_IDLE;
      r_Work_Bcd <= '0;
      r_Work_Bin <= '0;
      r_Loop     <= '0;
      r_Idx      <= '0;
      r_Invalid  <= 1'b0;
      o_Binary   <= '0;
      o_DV       <= 1'b0;
      o_Error    <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      case (r_State)
        S_IDLE: begin
          if (i_Start) begin
            r_Work_Bcd <= i_BCD;
            r_Work_Bin <= '0;
            o_Busy     <= 1'b1;
            if (w_Bad_Digit) begin
              // Pass through the terminal loop check so a bad digit reports two edges after start.
              r_Invalid <= 1'b1;
              r_Loop    <= LAST_LOOP;
              r_State   <= S_CHECK_SHIFT_INDEX;
            end else begin
              r_State <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          {r_Work_Bcd, r_Work_Bin} <= w_Shift;
          r_State <= S_CHECK_SHIFT_INDEX;
        end

        S_CHECK_SHIFT_INDEX: begin
          if (r_Loop == LAST_LOOP) begin
            r_Loop  <= '0;
            r_State <= S_DONE;
          end else begin
            r_Loop  <= r_Loop + 8'd1;
            r_State <= S_SUB;
          end
        end

        S_SUB: begin
          if (w_Digit >= 4'd8) r_Work_Bcd[{r_Idx, 2'b00} +: 4] <= w_Digit - 4'd3;
          r_State <= S_CHECK_DIGIT_INDEX;
        end

        S_CHECK_DIGIT_INDEX: begin
          if (r_Idx == LAST_IDX) begin
            r_Idx   <= '0;
            r_State <= S_SHIFT;
          end else begin
            r_Idx   <= r_Idx + 1'b1;
            r_State <= S_SUB;
          end
        end

        S_DONE: begin
          // Any BCD residue left after the final shift means the value did not fit.
          o_DV      <= 1'b1;
          o_Error   <= r_Invalid | (r_Work_Bcd != '0);
          o_Binary  <= r_Invalid ? '0 : r_Work_Bin;
          o_Busy    <= 1'b0;
          r_Invalid <= 1'b0;
          r_State   <= S_IDLE;
        end

        default: begin
          o_Busy  <= 1'b0;
          r_State <= S_IDLE;
        end
      endcase
    end
  end

endmodule
